dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache controller between the CPU's 8-bit data port (mem_read/mem_write/ALURESULT/REGOUT1/READDATA/busywait) and the 32-bit-block main data memory. It owns tag/valid/dirty state and the miss FSM. It also sequences the memory handshake, asserting CPU busywait until each access completes. Instantiated beside cpu; replaces the direct cpu-to-memory connection.

Parameters:
ADDR_W, 8, CPU byte-address width
INDEX_W, 3, line index bits (2**INDEX_W lines)
OFFSET_W, 2, byte offset bits (block = 4 bytes, fixed)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (3), derived tag width

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  asynchronous, active-low reset
read  in  1  CPU load request
write  in  1  CPU store request
address  in  ADDR_W  CPU byte address: tag [7:5], index [4:2], offset [1:0]
writedata  in  8  CPU store data
readdata  out  8  CPU load data
busywait  out  1  stall to CPU
mem_read  out  1  block read strobe to memory
mem_write  out  1  block write strobe to memory
mem_address  out  ADDR_W-OFFSET_W  block address {tag,index}
mem_writedata  out  32  victim block, byte0 in [7:0]
mem_readdata  in  32  fetched block
mem_busywait  in  1  memory busy

Behaviour:
- RESET low (async): all valid/dirty = 0, state IDLE, busywait/mem_read/mem_write = 0, readdata = 0. Strobes drop immediately when reset occurs mid-transfer; the line being filled stays invalid.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- hit = valid[index] && tag[index]==address tag (combinational).
- busywait = (read|write) && !hit in IDLE; busywait = 1 in WRITEBACK/FETCH/UPDATE.
- Read hit: readdata = selected byte combinationally, with zero-cycle stall.
- Write hit: byte written and dirty set at the next posedge, with zero-cycle stall.
- read and write both high: treated as write.
- Miss in IDLE: latch address/writedata/op at the posedge. Go to WRITEBACK if the victim is valid && dirty, else go to FETCH.
- WRITEBACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block. On a posedge with mem_busywait=0, go to FETCH.
- FETCH: mem_read=1, mem_address={latched tag,index}. On a posedge with mem_busywait=0, go to UPDATE.
- UPDATE: write mem_readdata into the line, set tag, valid=1, dirty=0, then go to IDLE. The held request then hits and busywait falls in that IDLE cycle; a pending write then sets dirty on the next posedge.
- Strobes are registered outputs of state; they are never high in IDLE/UPDATE, and mem_read and mem_write are never high together.
- CPU holds read/write/address stable while busywait=1. The controller uses the latched copy during a miss.
- Clean miss stall: 1 (detect) + memory latency + 1 (UPDATE). Dirty miss adds one full memory write.
- No request: no state change and no strobes.

Optional Feature:
DCACHE_STATS_EN: when defined, adds outputs hit_count[15:0] and miss_count[15:0], both saturating at 16'hFFFF and cleared by RESET. A counter increments once per CPU access, on the posedge where the access is first seen in IDLE; the retry hit after UPDATE is not counted. When undefined, the ports and counters are absent.

Decomposition:
- Package dcache_pkg: state enum (IDLE, WRITEBACK, FETCH, UPDATE), ADDR_W/INDEX_W/OFFSET_W/TAG_W defaults, block width 32.
- Sub-module dcache_line_array: data/tag/valid/dirty storage with async clear, byte-write port and block-write port.
- The FSM stays in dcache_controller.

Test Plan:
- Reset then read 0x25 (memory model latency 5) -> busywait 7 cycles; mem_read with mem_address 0x09; readdata = byte1 of block 0x09; valid[1]=1, dirty[1]=0.
- Immediately read 0x26 -> hit, busywait never high, readdata = byte2 of the same block.
- write 0x27 data 0xAB -> zero stall; dirty[1]=1; then read 0x27 -> 0xAB.
- read 0x45 (same index, tag 2) -> mem_write with mem_address 0x09 and mem_writedata[31:24]=0xAB, then mem_read 0x11; total stall 5+5+2 cycles.
- RESET pulsed low during FETCH -> mem_read drops asynchronously; line 1 invalid; a later read 0x45 misses again.
- With DCACHE_STATS_EN: the sequence above -> hit_count=3, miss_count=3.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped data cache.
// The optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int INDEX_W_DEF  = 3;
  localparam int OFFSET_W_DEF = 2;
  localparam int TAG_W_DEF    = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF;
  localparam int BLOCK_W      = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  // Byte 0 of a block lives in bits [7:0].
  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus bundles of the data cache controller.
// master drives the request signals, slave answers them.
interface dcache_cpu_if #(
  parameter int ADDR_W = dcache_pkg::ADDR_W_DEF
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic              busywait;

  modport master (output read, write, address, writedata, input readdata, busywait);
  modport slave  (input read, write, address, writedata, output readdata, busywait);
endinterface

interface dcache_mem_if #(
  parameter int ADDR_W   = dcache_pkg::ADDR_W_DEF,
  parameter int OFFSET_W = dcache_pkg::OFFSET_W_DEF,
  parameter int BLOCK_W  = dcache_pkg::BLOCK_W
);
  logic                       mem_read;
  logic                       mem_write;
  logic [ADDR_W-OFFSET_W-1:0] mem_address;
  logic [BLOCK_W-1:0]         mem_writedata;
  logic [BLOCK_W-1:0]         mem_readdata;
  logic                       mem_busywait;

  modport master (output mem_read, mem_write, mem_address, mem_writedata,
                  input mem_readdata, mem_busywait);
  modport slave  (input mem_read, mem_write, mem_address, mem_writedata,
                  output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_line_array.sv
// Line storage for the cache: block data and tags (no reset) plus valid/dirty
// bits cleared asynchronously. A byte write marks the line dirty; a block fill marks it clean.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic [BLOCK_W-1:0]  rd_block,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  input  logic                byte_we,
  input  logic [INDEX_W-1:0]  byte_index,
  input  logic [OFFSET_W-1:0] byte_offset,
  input  logic [7:0]          byte_data,
  input  logic                blk_we,
  input  logic [INDEX_W-1:0]  blk_index,
  input  logic [TAG_W-1:0]    blk_tag,
  input  logic [BLOCK_W-1:0]  blk_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [BLOCK_W-1:0] data_q [LINES];
  logic [BLOCK_W-1:0] data_d [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (blk_we) begin
      data_d[blk_index]  = blk_data;
      tag_d[blk_index]   = blk_tag;
      valid_d[blk_index] = 1'b1;
      dirty_d[blk_index] = 1'b0;
    end
    if (byte_we) begin
      data_d[byte_index][{byte_offset, 3'b000} +: 8] = byte_data;
      dirty_d[byte_index] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge CLK) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign rd_block = data_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller with the miss FSM.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  dcache_cpu_if.slave cpu,
  dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLK_A_W = ADDR_W - OFFSET_W;

  state_e               state_q, state_d;
  logic [BLK_A_W-1:0]   lat_blk_q, lat_blk_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;

  logic [TAG_W-1:0]     req_tag, lat_tag, rd_tag;
  logic [INDEX_W-1:0]   req_index, lat_index, rd_index;
  logic [OFFSET_W-1:0]  req_offset;
  logic [BLOCK_W-1:0]   rd_block;
  logic                 rd_valid, rd_dirty;
  logic                 access, hit, busy, byte_we, blk_we;
  logic [7:0]           readdata;
  logic [BLK_A_W-1:0]   mem_addr;

  assign req_tag    = cpu.address[ADDR_W-1 -: TAG_W];
  assign req_index  = cpu.address[OFFSET_W +: INDEX_W];
  assign req_offset = cpu.address[OFFSET_W-1:0];
  assign lat_tag    = lat_blk_q[BLK_A_W-1 -: TAG_W];
  assign lat_index  = lat_blk_q[INDEX_W-1:0];

  // Outside IDLE the array is addressed by the latched miss, so the victim stays visible.
  assign rd_index = (state_q == IDLE) ? req_index : lat_index;
  assign access   = cpu.read | cpu.write;
  assign hit      = rd_valid && (rd_tag == req_tag);

  dcache_line_array #(
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W),
    .OFFSET_W (OFFSET_W)
  ) u_lines (
    .CLK         (CLK),
    .RESET       (RESET),
    .rd_index    (rd_index),
    .rd_block    (rd_block),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .byte_we     (byte_we),
    .byte_index  (req_index),
    .byte_offset (req_offset),
    .byte_data   (cpu.writedata),
    .blk_we      (blk_we),
    .blk_index   (lat_index),
    .blk_tag     (lat_tag),
    .blk_data    (mem.mem_readdata)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_ff @(posedge CLK) begin
    lat_blk_q <= lat_blk_d;
  end

  always_comb begin
    state_d   = state_q;
    lat_blk_d = lat_blk_q;
    case (state_q)
      IDLE: begin
        if (access && !hit) begin
          lat_blk_d = cpu.address[ADDR_W-1:OFFSET_W];
          state_d   = (rd_valid && rd_dirty) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: if (!mem.mem_busywait) state_d = FETCH;
      FETCH:     if (!mem.mem_busywait) state_d = UPDATE;
      UPDATE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Strobes are registered copies of the state being entered.
    mem_read_d  = (state_d == FETCH);
    mem_write_d = (state_d == WRITEBACK);
  end

  always_comb begin
    busy     = 1'b1;
    readdata = '0;
    byte_we  = 1'b0;
    blk_we   = 1'b0;
    mem_addr = lat_blk_q;
    case (state_q)
      IDLE: begin
        busy    = access && !hit;
        byte_we = hit && cpu.write;
        if (hit && cpu.read && !cpu.write) readdata = block_byte(rd_block, req_offset);
      end
      WRITEBACK: mem_addr = {rd_tag, lat_index};
      UPDATE:    blk_we = 1'b1;
      default:   ;
    endcase
  end

  // Reset forces the stall low immediately even while a request is held.
  assign cpu.busywait      = RESET & busy;
  assign cpu.readdata      = readdata;
  assign mem.mem_read      = mem_read_q;
  assign mem.mem_write     = mem_write_q;
  assign mem.mem_address   = mem_addr;
  assign mem.mem_writedata = rd_block;

`ifdef DCACHE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        retry_q, retry_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        first_seen;

  // The IDLE cycle right after UPDATE replays the stalled access; it is not a new one.
  assign first_seen = (state_q == IDLE) && access && !retry_q;

  always_comb begin
    retry_d    = (state_q == UPDATE);
    hit_cnt_d  = (first_seen && hit)  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
    miss_cnt_d = (first_seen && !hit) ? sat_inc(miss_cnt_q) : miss_cnt_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model.
// Statistic checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int LAT = 5;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dcache_cpu_if cpu_bus ();
  dcache_mem_if mem_bus ();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_controller dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Memory model: byte at address a holds a ^ 8'hC3 until written back.
  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  function automatic logic [31:0] init_block(input logic [5:0] b);
    return {mem_byte({b, 2'd3}), mem_byte({b, 2'd2}), mem_byte({b, 2'd1}), mem_byte({b, 2'd0})};
  endfunction

  logic [31:0] wr_data [64];
  logic [63:0] wr_valid = '0;
  int          mem_cnt  = 0;

  assign mem_bus.mem_busywait = (mem_bus.mem_read | mem_bus.mem_write) && (mem_cnt != LAT - 1);
  assign mem_bus.mem_readdata = wr_valid[mem_bus.mem_address] ? wr_data[mem_bus.mem_address]
                                                              : init_block(mem_bus.mem_address);

  always @(posedge CLK) begin
    if (mem_bus.mem_read || mem_bus.mem_write) begin
      if (!mem_bus.mem_busywait) begin
        mem_cnt <= 0;
        if (mem_bus.mem_write) begin
          wr_data[mem_bus.mem_address]  <= mem_bus.mem_writedata;
          wr_valid[mem_bus.mem_address] <= 1'b1;
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         stall;
    logic       chk_rd;
    logic [7:0] rdata;
    logic       wb;
    logic [5:0] wb_addr;
    logic [31:0] wb_data;
    logic       fetch;
    logic [5:0] fetch_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic apply_vec(input int i);
    int          stall;
    logic        done, saw_wb, saw_fetch, both;
    logic [7:0]  rdata;
    logic [5:0]  wb_addr, fetch_addr;
    logic [31:0] wb_data;
    cpu_bus.read      = vecs[i].rd;
    cpu_bus.write     = vecs[i].wr;
    cpu_bus.address   = vecs[i].addr;
    cpu_bus.writedata = vecs[i].wdata;
    stall = 0; done = 1'b0; saw_wb = 1'b0; saw_fetch = 1'b0; both = 1'b0;
    rdata = '0; wb_addr = '0; fetch_addr = '0; wb_data = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (mem_bus.mem_write && !saw_wb) begin
        saw_wb  = 1'b1;
        wb_addr = mem_bus.mem_address;
        wb_data = mem_bus.mem_writedata;
      end
      if (mem_bus.mem_read && !saw_fetch) begin
        saw_fetch  = 1'b1;
        fetch_addr = mem_bus.mem_address;
      end
      if (mem_bus.mem_read && mem_bus.mem_write) both = 1'b1;
      if (!cpu_bus.busywait) begin
        done  = 1'b1;
        rdata = cpu_bus.readdata;
      end else begin
        stall++;
      end
    end
    @(posedge CLK);
    #1;
    cpu_bus.read  = 1'b0;
    cpu_bus.write = 1'b0;
    check($sformatf("v%0d completed", i), 32'(done), 32'd1);
    check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].stall));
    if (vecs[i].chk_rd) check($sformatf("v%0d readdata", i), 32'(rdata), 32'(vecs[i].rdata));
    check($sformatf("v%0d writeback seen", i), 32'(saw_wb), 32'(vecs[i].wb));
    if (vecs[i].wb) begin
      check($sformatf("v%0d wb address", i), 32'(wb_addr), 32'(vecs[i].wb_addr));
      check($sformatf("v%0d wb data", i), wb_data, vecs[i].wb_data);
    end
    check($sformatf("v%0d fetch seen", i), 32'(saw_fetch), 32'(vecs[i].fetch));
    if (vecs[i].fetch) check($sformatf("v%0d fetch address", i), 32'(fetch_addr), 32'(vecs[i].fetch_addr));
    check($sformatf("v%0d strobes overlap", i), 32'(both), 32'd0);
  endtask

  initial begin
    logic seen;
    //           rd    wr    addr   wdata  stall chk  rdata  wb    wb_a   wb_data        fetch fetch_a
    vecs[0]  = '{1'b1, 1'b0, 8'h25, 8'h00, 7,  1'b1, 8'hE6, 1'b0, 6'h00, 32'h0,         1'b1, 6'h09};
    vecs[1]  = '{1'b1, 1'b0, 8'h26, 8'h00, 0,  1'b1, 8'hE5, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h27, 8'hAB, 0,  1'b0, 8'h00, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h27, 8'h00, 0,  1'b1, 8'hAB, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00};
    vecs[4]  = '{1'b1, 1'b0, 8'h45, 8'h00, 12, 1'b1, 8'h86, 1'b1, 6'h09, 32'hABE5E6E7, 1'b1, 6'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'h0C, 8'h5A, 7,  1'b0, 8'h00, 1'b0, 6'h00, 32'h0,         1'b1, 6'h03};
    vecs[6]  = '{1'b1, 1'b0, 8'h0C, 8'h00, 0,  1'b1, 8'h5A, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h6C, 8'h00, 12, 1'b1, 8'hAF, 1'b1, 6'h03, 32'hCCCDCE5A, 1'b1, 6'h1B};
    vecs[8]  = '{1'b1, 1'b1, 8'h6D, 8'h77, 0,  1'b0, 8'h00, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00};
    vecs[9]  = '{1'b1, 1'b0, 8'h6D, 8'h00, 0,  1'b1, 8'h77, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00};
    vecs[10] = '{1'b1, 1'b0, 8'h45, 8'h00, 7,  1'b1, 8'h86, 1'b0, 6'h00, 32'h0,         1'b1, 6'h11};
    vecs[11] = '{1'b1, 1'b0, 8'h25, 8'h00, 7,  1'b1, 8'hE6, 1'b0, 6'h00, 32'h0,         1'b1, 6'h09};

    // Reset with a request already held: everything must stay quiet.
    RESET = 1'b0;
    cpu_bus.read = 1'b1; cpu_bus.write = 1'b0; cpu_bus.address = 8'h25; cpu_bus.writedata = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset busywait", 32'(cpu_bus.busywait), 32'd0);
    check("reset mem_read", 32'(mem_bus.mem_read), 32'd0);
    check("reset mem_write", 32'(mem_bus.mem_write), 32'd0);
    check("reset readdata", 32'(cpu_bus.readdata), 32'd0);
    cpu_bus.read = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("idle quiet", 32'({cpu_bus.busywait, mem_bus.mem_read, mem_bus.mem_write}), 32'd0);
    end
    @(posedge CLK);
    #1;

    for (int i = 0; i < 6; i++) apply_vec(i);
`ifdef DCACHE_STATS_EN
    check("hit_count", 32'(hit_count), 32'd3);
    check("miss_count", 32'(miss_count), 32'd3);
`endif
    for (int i = 6; i < 10; i++) apply_vec(i);

    // Asynchronous reset in the middle of a line fetch.
    cpu_bus.read = 1'b1; cpu_bus.address = 8'h25;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (mem_bus.mem_read) begin
        seen = 1'b1;
        break;
      end
    end
    check("fetch started before reset", 32'(seen), 32'd1);
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    check("async reset mem_read", 32'(mem_bus.mem_read), 32'd0);
    check("async reset mem_write", 32'(mem_bus.mem_write), 32'd0);
    check("async reset busywait", 32'(cpu_bus.busywait), 32'd0);
    cpu_bus.read = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
`ifdef DCACHE_STATS_EN
    check("hit_count cleared", 32'(hit_count), 32'd0);
    check("miss_count cleared", 32'(miss_count), 32'd0);
`endif
    @(posedge CLK);
    #1;
    apply_vec(10);
    apply_vec(11);
`ifdef DCACHE_STATS_EN
    check("hit_count after reset", 32'(hit_count), 32'd0);
    check("miss_count after reset", 32'(miss_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
